// File: rtl/spi_slave_rx_if.sv
// Bus bundle for the SPI receive block: serial pins from the master plus the
// byte-level valid/ready output side and status flags.
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport slave (
        input  sclk, cs, mosi, rx_ready,
        output rx_data, rx_valid, frame_err, overrun, busy
    );

    modport master (
        output sclk, cs, mosi, rx_ready,
        input  rx_data, rx_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive side: oversamples sclk/cs/mosi in the clk domain, shifts an
// MSB-first byte per cs assertion into a one-entry valid/ready holding register.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int LEAD_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_rx_if.slave bus
);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int EDGE_W = (LEAD_EDGES < 2) ? 1 : $clog2(LEAD_EDGES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        WAIT_CS
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_prev_reg;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic fall;

    state_t              state_reg, state_next;
    logic [EDGE_W-1:0]   edge_cnt_reg, edge_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-2:0]   shreg_reg, shreg_next;
    logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
    logic                rx_valid_reg, rx_valid_next;
    logic                frame_err_reg, frame_err_next;
    logic                overrun_reg, overrun_next;

    logic                deliver;
    logic                lead_done;
    logic                last_bit;
    logic [DATA_W-1:0]   new_byte;

    // cs idles high so a reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_reg   <= '1;
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            sclk_prev_reg <= 1'b0;
        end else begin
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs};
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev_reg <= sclk_s;
        end
    end

    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign fall   = sclk_prev_reg & ~sclk_s;

    assign new_byte  = {shreg_reg, mosi_s};
    assign lead_done = (32'(edge_cnt_reg) + 32'd1 == 32'(LEAD_EDGES));
    assign last_bit  = (bit_cnt_reg == BIT_W'(DATA_W - 1));

    always_comb begin
        state_next     = state_reg;
        edge_cnt_next  = edge_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shreg_next     = shreg_reg;
        deliver        = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!cs_s) begin
                    edge_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = (LEAD_EDGES == 0) ? SHIFT : LEAD;
                end
            end
            LEAD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (fall) begin
                    if (lead_done) state_next = SHIFT;
                    else           edge_cnt_next = edge_cnt_reg + 1'b1;
                end
            end
            SHIFT: begin
                // The final fall wins over a simultaneous cs rise.
                if (fall && last_bit) begin
                    deliver    = 1'b1;
                    state_next = cs_s ? IDLE : WAIT_CS;
                end else if (cs_s) begin
                    frame_err_next = (bit_cnt_reg != '0);
                    state_next     = IDLE;
                end else if (fall) begin
                    shreg_next   = new_byte[DATA_W-2:0];
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            WAIT_CS: begin
                if (cs_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding register: a full, unconsumed entry keeps its byte and the newcomer is dropped.
    always_comb begin
        rx_data_next  = rx_data_reg;
        rx_valid_next = rx_valid_reg;
        overrun_next  = 1'b0;
        if (deliver) begin
            if (!rx_valid_reg || bus.rx_ready) begin
                rx_data_next  = new_byte;
                rx_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (rx_valid_reg && bus.rx_ready) begin
            rx_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            edge_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            edge_cnt_reg  <= edge_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shreg_reg     <= shreg_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bus.rx_data   = rx_data_reg;
    assign bus.rx_valid  = rx_valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a bit-banged SPI master queues the expected
// byte/overrun/frame-error events; a monitor pops them as the DUT reports them.
module tb_spi_slave_rx;
    localparam int DATA_W      = 8;
    localparam int LEAD_EDGES  = 1;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    typedef enum int { EV_BYTE, EV_OVR, EV_FERR } ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    spi_slave_rx_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_rx #(
        .DATA_W     (DATA_W),
        .LEAD_EDGES (LEAD_EDGES),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  model_held = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_ev(ev_kind_t k, logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Reference for the holding register: a byte finishing while ready is low
    // and a byte is already parked is lost as an overrun.
    function automatic void model_byte(logic [7:0] d);
        if (bus.rx_ready) begin
            push_ev(EV_BYTE, d);
        end else if (!model_held) begin
            push_ev(EV_BYTE, d);
            model_held = 1'b1;
        end else begin
            push_ev(EV_OVR, 8'h00);
        end
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_ready(bit r);
        bus.rx_ready = r;
        if (r) model_held = 1'b0;
        tick(2);
    endtask

    task automatic sclk_bit(bit d);
        bus.sclk = 1'b1;
        tick(HALF / 2);
        bus.mosi = d;
        tick(HALF / 2);
        bus.sclk = 1'b0;
    endtask

    // nbits < DATA_W sends a truncated frame; ready_late raises rx_ready around delivery.
    task automatic send_frame(logic [7:0] d, int nbits, bit ready_late);
        int waited;
        bus.cs = 1'b0;
        tick(3);
        repeat (LEAD_EDGES) begin
            sclk_bit(1'b0);
            tick(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(d[DATA_W-1-i]);
            if (i == DATA_W - 1) begin
                if (ready_late) begin
                    push_ev(EV_BYTE, d);
                    tick(2);
                    bus.rx_ready = 1'b1;
                    model_held   = 1'b0;
                    tick(2);
                end else begin
                    model_byte(d);
                    tick(HALF);
                end
            end else begin
                tick(HALF);
            end
        end
        tick(2);
        bus.cs = 1'b1;
        if (nbits > 0 && nbits < DATA_W) push_ev(EV_FERR, 8'h00);
        waited = 0;
        while (bus.busy && waited < SYNC_STAGES + 1) begin
            tick(1);
            waited++;
        end
        check("busy_clear", 32'(bus.busy), 32'd0);
        tick(4);
    endtask

    task automatic expect_ev(ev_kind_t k, logic [7:0] d, string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected event data 0x%0h expected none", name, d);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, 32'(k), 32'(e.kind));
            if (k == EV_BYTE && e.kind == EV_BYTE) check({name, "_data"}, 32'(d), 32'(e.data));
            $display("event %s data 0x%02h", name, d);
        end
    endtask

    // Monitor: samples on the falling clk edge, away from the DUT's active edge.
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (bus.frame_err) expect_ev(EV_FERR, 8'h00, "frame_err");
                if (bus.overrun)   expect_ev(EV_OVR, 8'h00, "overrun");
                if (bus.rx_valid && (!pv || pr)) expect_ev(EV_BYTE, bus.rx_data, "rx_byte");
                if (pv && !pr) begin
                    check("hold_valid", 32'(bus.rx_valid), 32'd1);
                    check("hold_data", 32'(bus.rx_data), 32'(pd));
                end
                pv = bus.rx_valid;
                pr = bus.rx_ready;
                pd = bus.rx_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        rst          = 1'b0;
        bus.cs       = 1'b1;
        bus.sclk     = 1'b0;
        bus.mosi     = 1'b0;
        bus.rx_ready = 1'b1;
        tick(3);
        check("rst_data", 32'(bus.rx_data), 32'd0);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_ferr", 32'(bus.frame_err), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        tick(4);

        // Single byte, then back-to-back pair, with the consumer always ready.
        send_frame(8'hA5, DATA_W, 1'b0);
        send_frame(8'h3C, DATA_W, 1'b0);
        send_frame(8'hFF, DATA_W, 1'b0);

        // Stalled consumer: second byte overruns, then draining clears valid.
        set_ready(1'b0);
        send_frame(8'h12, DATA_W, 1'b0);
        send_frame(8'h34, DATA_W, 1'b0);
        set_ready(1'b1);
        check("drain_valid", 32'(bus.rx_valid), 32'd0);

        // Truncated frame after 4 bits.
        send_frame(8'hC3, 4, 1'b0);

        // Asynchronous reset after 5 data bits.
        bus.cs = 1'b0;
        tick(3);
        sclk_bit(1'b0);
        tick(HALF);
        for (int i = 0; i < 5; i++) begin
            sclk_bit(1'b1);
            tick(HALF);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_data", 32'(bus.rx_data), 32'd0);
        check("arst_valid", 32'(bus.rx_valid), 32'd0);
        check("arst_ferr", 32'(bus.frame_err), 32'd0);
        check("arst_ovr", 32'(bus.overrun), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(4);
        send_frame(8'h81, DATA_W, 1'b0);

        // Park 0x55, then release the consumer right at 0xAA's delivery.
        set_ready(1'b0);
        send_frame(8'h55, DATA_W, 1'b0);
        send_frame(8'hAA, DATA_W, 1'b1);
        set_ready(1'b1);

        // Randomized traffic: mixed ready policy and occasional truncated frames.
        for (int n = 0; n < 40; n++) begin
            set_ready(($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
            kind = $urandom_range(0, 9);
            if (kind == 0) send_frame(8'($urandom), $urandom_range(0, DATA_W - 1), 1'b0);
            else           send_frame(8'($urandom), DATA_W, 1'b0);
            tick($urandom_range(0, 5));
        end

        set_ready(1'b1);
        tick(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
